// File: rtl/alu.sv
// alu: RV32I-style integer ALU and branch comparator with a registered copy of both results
package lx32_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;
endpackage

package branches_pkg;
  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LT  = 3'd2,
    BR_GE  = 3'd3,
    BR_LTU = 3'd4,
    BR_GEU = 3'd5
  } branch_op_e;
endpackage

module alu
  import lx32_pkg::*;
  import branches_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic       [WIDTH-1:0] src_a,
  input  logic       [WIDTH-1:0] src_b,
  input  alu_op_e                alu_control,
  input  logic                   is_branch,
  input  branch_op_e             branch_op,
  output logic       [WIDTH-1:0] alu_result,
  output logic                   alu_branch_true,
  output logic       [WIDTH-1:0] alu_result_q,
  output logic                   alu_branch_true_q
);
  localparam int SW = $clog2(WIDTH);
  logic [SW-1:0] w_sh;
  logic w_eq, w_lt, w_ltu, w_cond, w_cmp_op;
  assign w_sh  = src_b[SW-1:0];
  assign w_eq  = src_a == src_b;
  assign w_lt  = $signed(src_a) < $signed(src_b);
  assign w_ltu = src_a < src_b;
  always_comb begin
    alu_result = '0;
    case (alu_control)
      ALU_ADD:  alu_result = src_a + src_b;
      ALU_SUB:  alu_result = src_a - src_b;
      ALU_AND:  alu_result = src_a & src_b;
      ALU_OR:   alu_result = src_a | src_b;
      ALU_XOR:  alu_result = src_a ^ src_b;
      ALU_SLL:  alu_result = src_a << w_sh;
      ALU_SRL:  alu_result = src_a >> w_sh;
      ALU_SRA:  alu_result = $unsigned($signed(src_a) >>> w_sh);
      ALU_SLT:  alu_result = {{(WIDTH-1){1'b0}}, w_lt};
      ALU_SLTU: alu_result = {{(WIDTH-1){1'b0}}, w_ltu};
      default:  alu_result = '0;
    endcase
  end
  always_comb begin
    w_cond = 1'b0;
    case (branch_op)
      BR_EQ:   w_cond = w_eq;
      BR_NE:   w_cond = !w_eq;
      BR_LT:   w_cond = w_lt;
      BR_GE:   w_cond = !w_lt;
      BR_LTU:  w_cond = w_ltu;
      BR_GEU:  w_cond = !w_ltu;
      default: w_cond = 1'b0;
    endcase
  end
  // Only compare-type ops may signal a taken branch
  assign w_cmp_op = alu_control inside {ALU_SUB, ALU_SLT, ALU_SLTU};
  assign alu_branch_true = is_branch & w_cond & w_cmp_op;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_q      <= '0;
      alu_branch_true_q <= 1'b0;
    end else begin
      alu_result_q      <= alu_result;
      alu_branch_true_q <= alu_branch_true;
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for alu with directed cases and a randomized reference model
module tb_alu;
  import lx32_pkg::*;
  import branches_pkg::*;
  typedef struct packed {
    logic [31:0] res;
    logic        br;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] src_a = '0, src_b = '0;
  alu_op_e     alu_control = ALU_ADD;
  logic        is_branch = 1'b0;
  branch_op_e  branch_op = BR_EQ;
  logic [31:0] alu_result, alu_result_q;
  logic        alu_branch_true, alu_branch_true_q;
  exp_t        q_comb[$], q_reg[$];
  int          n_cmp = 0, n_bad = 0;
  logic        mon_en = 1'b0;

  alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .src_a(src_a), .src_b(src_b),
    .alu_control(alu_control), .is_branch(is_branch), .branch_op(branch_op),
    .alu_result(alu_result), .alu_branch_true(alu_branch_true),
    .alu_result_q(alu_result_q), .alu_branch_true_q(alu_branch_true_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (a=%h b=%h op=%0d br=%0d isb=%0b)",
               name, act, req, src_a, src_b, alu_control, branch_op, is_branch);
    end
  endtask

  // Reference: signed order via sign-bit flip, arithmetic shift built from a logical shift plus fill
  function automatic exp_t model(input int op, input int br, input logic isb,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int sh = int'(b % 32);
    logic slt = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    logic cond;
    case (op)
      0: e.res = a + b;
      1: e.res = a - b;
      2: e.res = a & b;
      3: e.res = a | b;
      4: e.res = a ^ b;
      5: e.res = a << sh;
      6: e.res = a >> sh;
      7: e.res = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      8: e.res = {31'b0, slt};
      9: e.res = {31'b0, a < b};
      default: e.res = 32'h0;
    endcase
    case (br)
      0: cond = a == b;
      1: cond = a != b;
      2: cond = slt;
      3: cond = !slt;
      4: cond = a < b;
      5: cond = a >= b;
      default: cond = 1'b0;
    endcase
    e.br = isb && cond && (op == 1 || op == 8 || op == 9);
    return e;
  endfunction

  task automatic send(input int op, input int br, input logic isb,
                      input logic [31:0] a, input logic [31:0] b, input exp_t e);
    @(posedge clk);
    #1;
    alu_control = alu_op_e'(4'(op));
    branch_op   = branch_op_e'(3'(br));
    is_branch   = isb;
    src_a       = a;
    src_b       = b;
    q_comb.push_back(e);
  endtask

  task automatic dir(input int op, input int br, input logic isb, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] er, input logic eb);
    send(op, br, isb, a, b, '{res: er, br: eb});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (q_reg.size() != 0) begin
        e = q_reg.pop_front();
        check("result_q", alu_result_q, e.res);
        check("branch_q", {31'b0, alu_branch_true_q}, {31'b0, e.br});
      end
      if (q_comb.size() != 0) begin
        e = q_comb.pop_front();
        check("result", alu_result, e.res);
        check("branch", {31'b0, alu_branch_true}, {31'b0, e.br});
        q_reg.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, b;
    int op, br;
    logic isb;
    #3;
    check("reset result_q", alu_result_q, 32'h0);
    check("reset branch_q", {31'b0, alu_branch_true_q}, 32'h0);
    #9 rst_n = 1'b1;
    mon_en = 1'b1;
    dir(0, 0, 1, 32'hA, 32'h5, 32'hF, 0);
    dir(1, 0, 1, 32'hA, 32'h5, 32'h5, 0);
    dir(8, 0, 1, 32'hFFFF_FFFF, 32'h1, 32'h1, 0);
    dir(9, 0, 1, 32'hFFFF_FFFF, 32'h1, 32'h0, 0);
    dir(9, 0, 1, 32'hF000_0000, 32'hF000_0000, 32'h0, 1);
    dir(9, 2, 1, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
    dir(9, 5, 1, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
    dir(9, 4, 1, 32'hFFFF_FFFF, 32'h1, 32'h0, 0);
    dir(9, 0, 0, 32'hF000_0000, 32'hF000_0000, 32'h0, 0);
    dir(9, 2, 0, 32'hFFFF_FFFF, 32'h1, 32'h0, 0);
    dir(9, 5, 0, 32'hFFFF_FFFF, 32'h1, 32'h0, 0);
    dir(7, 1, 1, 32'h8000_0000, 32'h1, 32'hC000_0000, 0);
    dir(6, 1, 1, 32'h8000_0000, 32'h1, 32'h4000_0000, 0);
    dir(5, 1, 1, 32'h8000_0000, 32'h1, 32'h0, 0);
    dir(7, 1, 1, 32'h8000_0000, 32'h21, 32'hC000_0000, 0);
    dir(6, 0, 1, 32'h8000_0000, 32'h21, 32'h4000_0000, 0);
    dir(5, 0, 1, 32'h1234_5678, 32'h20, 32'h1234_5678, 0);
    dir(2, 0, 1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0);
    dir(3, 0, 1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0);
    dir(4, 0, 1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0);
    dir(1, 2, 1, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 1);
    dir(1, 4, 1, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 0);
    dir(1, 5, 1, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 1);
    dir(8, 3, 1, 32'h1234_5678, 32'h1234_5678, 32'h0, 1);
    dir(1, 7, 1, 32'h5, 32'h5, 32'h0, 0);
    dir(15, 0, 1, 32'h5, 32'h5, 32'h0, 0);
    for (int i = 0; i < 300; i++) begin
      a   = pick();
      b   = ($urandom_range(0, 7) == 0) ? a : pick();
      op  = $urandom_range(0, 15);
      br  = $urandom_range(0, 7);
      isb = 1'($urandom_range(0, 1));
      send(op, br, isb, a, b, model(op, br, isb, a, b));
    end
    repeat (3) @(negedge clk);
    #1 mon_en = 1'b0;
    @(posedge clk);
    #1;
    alu_control = ALU_ADD;
    branch_op   = BR_EQ;
    is_branch   = 1'b1;
    src_a       = 32'hA;
    src_b       = 32'h5;
    @(posedge clk);
    #2;
    check("reg after edge", alu_result_q, 32'hF);
    #2 rst_n = 1'b0;
    #1;
    check("async clr result_q", alu_result_q, 32'h0);
    check("async clr branch_q", {31'b0, alu_branch_true_q}, 32'h0);
    check("comb during reset", alu_result, 32'hF);
    @(posedge clk);
    #1;
    check("held in reset", alu_result_q, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("recapture", alu_result_q, 32'hF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
